// File: rtl/circ_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circ_buf_ctrl_pkg
//  Description : Shared FSM state encoding, width helpers and default
//                geometry for the circular column-buffer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package circ_buf_ctrl_pkg;

  // Controller states; 2-bit encoding is shared with anything that observes
  // the controller (e.g. debug taps, benches).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no columns held
    ST_FILL  = 2'd1,  // some columns, but fewer than one read group
    ST_AVAIL = 2'd2,  // at least one full read group available
    ST_FLUSH = 2'd3   // one-cycle drain after a flush request
  } state_t;

  // Default buffer geometry.
  localparam int DEF_COLUMNS  = 32;
  localparam int DEF_PAR_READ = 4;

  // Column-address width for a buffer of the given depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so that "completely full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_width(DEF_COLUMNS);
  localparam int DEF_CNT_W = cnt_width(DEF_COLUMNS);

endpackage : circ_buf_ctrl_pkg
`default_nettype wire

// File: rtl/circ_buf_ctrl_wrap_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_ptr
//  Description : Modulo-DEPTH pointer that advances by STEP on each inc.
//                The sum is formed one bit wider than the pointer so that a
//                single conditional subtract gives the wrapped address.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_ptr #(
  parameter int DEPTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int W  = $clog2(DEPTH);
  localparam int SW = W + 1;

  localparam logic [SW-1:0] C_STEP  = SW'(STEP);
  localparam logic [SW-1:0] C_DEPTH = SW'(DEPTH);

  logic [SW-1:0] sum;
  logic [W-1:0]  ptr_next;

  // Widened add followed by a single conditional subtract of DEPTH.
  always_comb begin
    sum      = {1'b0, ptr} + C_STEP;
    ptr_next = (sum >= C_DEPTH) ? W'(sum - C_DEPTH) : W'(sum);
  end

  // Pointer register: reset and clear both return to column 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr_next;
    end
  end

endmodule : wrap_ptr
`default_nettype wire

// File: rtl/circ_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : circ_buf_ctrl
//  Description : Pointer/occupancy controller for a circular column buffer.
//                Writes are one column at a time, reads consume PAR_READ
//                columns per handshake. The buffer memory itself lives
//                outside this block.
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_buf_ctrl
  import circ_buf_ctrl_pkg::*;
#(
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int PAR_READ = DEF_PAR_READ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       wen,
  output logic [$clog2(COLUMNS)-1:0] write_ptr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(COLUMNS)-1:0] read_ptr,
  input  logic                       flush,
  output logic [$clog2(COLUMNS):0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = cnt_width(COLUMNS);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(COLUMNS);
  localparam logic [CNT_W-1:0] C_PAR  = CNT_W'(PAR_READ);

  // Reject geometries where read groups would straddle the wrap point.
  generate
    if (PAR_READ < 1 || PAR_READ > COLUMNS) begin : g_bad_par_range
      $error("circ_buf_ctrl: PAR_READ must be in 1..COLUMNS");
    end else if ((COLUMNS % PAR_READ) != 0) begin : g_bad_par_mod
      $error("circ_buf_ctrl: COLUMNS must be a multiple of PAR_READ");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic             rd_hs;
  logic [CNT_W-1:0] count_next;

  // Handshake decode. Readiness looks only at the registered count, so a read
  // in the same cycle never lends a slot to a write. Reset forces the idle
  // view of the interface regardless of flush or handshakes.
  always_comb begin
    wr_ready = rst ? 1'b1 : (!flush && (state != ST_FLUSH) && (count < C_FULL));
    rd_valid = !rst && !flush && (state == ST_AVAIL);
    wen      = !rst && wr_valid && wr_ready;
    rd_hs    = rd_valid && rd_ready;
    full     = !rst && (count == C_FULL);
    empty    = rst || (count == '0);
  end

  // Next occupancy and the state it implies; flush overrides both.
  always_comb begin
    count_next = count + {{(CNT_W-1){1'b0}}, wen} - (rd_hs ? C_PAR : '0);
    state_next = state;
    if (flush) begin
      state_next = ST_FLUSH;
    end else if (count_next == '0) begin
      state_next = ST_EMPTY;
    end else if (count_next < C_PAR) begin
      state_next = ST_FILL;
    end else begin
      state_next = ST_AVAIL;
    end
  end

  // State and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      count <= '0;
    end else if (flush) begin
      state <= ST_FLUSH;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  wrap_ptr #(
    .DEPTH (COLUMNS),
    .STEP  (1)
  ) u_write_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .inc   (wen),
    .ptr   (write_ptr)
  );

  wrap_ptr #(
    .DEPTH (COLUMNS),
    .STEP  (PAR_READ)
  ) u_read_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .inc   (rd_hs),
    .ptr   (read_ptr)
  );

endmodule : circ_buf_ctrl
`default_nettype wire

// File: tb/tb_circ_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circ_buf_ctrl
//  Description : Self-checking bench for circ_buf_ctrl (32 columns, groups of
//                4) using an occupancy/pointer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circ_buf_ctrl;
  import circ_buf_ctrl_pkg::*;

  localparam int C = 32;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wen;
  logic [4:0] write_ptr;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] read_ptr;
  logic       flush = 1'b0;
  logic [5:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain occupancy plus two modular addresses.
  int m_occ = 0;
  int m_wp  = 0;
  int m_rp  = 0;
  bit m_flushing = 1'b0;

  circ_buf_ctrl #(.COLUMNS(C), .PAR_READ(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wen       (wen),
    .write_ptr (write_ptr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .read_ptr  (read_ptr),
    .flush     (flush),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle against the
  // model, then advance the model on the rising edge.
  task automatic step(input bit wv, input bit rr, input bit fl, input bit rs);
    bit     e_ready, e_valid, e_wen, e_rd;
    state_t e_st;
    wr_valid = wv;
    rd_ready = rr;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
    e_ready = rs ? 1'b1 : (!fl && !m_flushing && m_occ < C);
    e_valid = !rs && !fl && !m_flushing && m_occ >= P;
    e_wen   = !rs && wv && e_ready;
    e_rd    = e_valid && rr;
    check("wr_ready", int'(wr_ready), int'(e_ready));
    check("rd_valid", int'(rd_valid), int'(e_valid));
    check("wen",      int'(wen),      int'(e_wen));
    check("full",     int'(full),     rs ? 0 : int'(m_occ == C));
    check("empty",    int'(empty),    rs ? 1 : int'(m_occ == 0));
    if (!rs) begin
      e_st = m_flushing ? ST_FLUSH :
             (m_occ == 0) ? ST_EMPTY :
             (m_occ < P)  ? ST_FILL  : ST_AVAIL;
      check("count",     int'(count),     m_occ);
      check("write_ptr", int'(write_ptr), m_wp);
      check("read_ptr",  int'(read_ptr),  m_rp);
      check("state",     int'(dut.state), int'(e_st));
    end
    @(posedge clk);
    if (rs || fl) begin
      m_occ = 0;
      m_wp  = 0;
      m_rp  = 0;
      m_flushing = !rs && fl;
    end else begin
      m_flushing = 1'b0;
      if (e_wen) begin
        m_occ++;
        m_wp = (m_wp + 1) % C;
      end
      if (e_rd) begin
        m_occ -= P;
        m_rp = (m_rp + P) % C;
      end
    end
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset.
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);

    // Three writes leave a partial group; the fourth completes it.
    repeat (3) step(1, 0, 0, 0);
    check("fill_count",    int'(count),     3);
    check("fill_state",    int'(dut.state), int'(ST_FILL));
    check("fill_rd_valid", int'(rd_valid),  0);
    step(1, 0, 0, 0);
    check("avail_count",    int'(count),    4);
    check("avail_rd_valid", int'(rd_valid), 1);
    check("avail_read_ptr", int'(read_ptr), 0);

    // Fill to capacity, then offer one more column.
    repeat (28) step(1, 0, 0, 0);
    check("full_flag",     int'(full),      1);
    check("full_wr_ready", int'(wr_ready),  0);
    check("full_wptr",     int'(write_ptr), 0);
    step(1, 0, 0, 0);
    check("full_count_hold", int'(count), 32);

    // Full with simultaneous write and read: only the read completes.
    step(1, 1, 0, 0);
    check("fullrw_count",    int'(count),    28);
    check("fullrw_wr_ready", int'(wr_ready), 1);

    // Drain down to read_ptr=28, then wrap.
    repeat (6) step(0, 1, 0, 0);
    check("pre_wrap_rptr", int'(read_ptr), 28);
    step(0, 1, 0, 0);
    check("wrap_rptr",  int'(read_ptr), 0);
    check("wrap_count", int'(count),    0);

    // Flush beats both handshakes at count=10.
    repeat (10) step(1, 0, 0, 0);
    check("pre_flush_count", int'(count), 10);
    step(1, 1, 1, 0);
    check("flush_state",    int'(dut.state), int'(ST_FLUSH));
    check("flush_wr_ready", int'(wr_ready),  0);
    step(1, 1, 0, 0);
    check("post_flush_state", int'(dut.state), int'(ST_EMPTY));
    check("post_flush_wptr",  int'(write_ptr), 0);
    check("post_flush_rptr",  int'(read_ptr),  0);

    // Reset concurrent with a read handshake at count=8.
    repeat (8) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    check("pre_rst_count", int'(count), 8);
    step(1, 1, 0, 1);
    check("rst_mid_count", int'(count),    0);
    check("rst_mid_rptr",  int'(read_ptr), 0);
    check("rst_mid_empty", int'(empty),    1);

    // Randomized traffic, first write-heavy then read-heavy.
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = (i < 1500) ? 35 : 80;
      step($urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < rd_pct,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_circ_buf_ctrl
`default_nettype wire

// File: doc/circ_buf_ctrl.md
CIRC_BUF_CTRL -- requirements
Module: circ_buf_ctrl

Interface
REQ-001 SHALL have parameter COLUMNS, default 32, buffer depth in columns.
REQ-002 SHALL have parameter PAR_READ, default 4, columns consumed per read handshake.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, producer offers one column this cycle.
REQ-006 SHALL have port wr_ready, output, 1, controller can accept one column.
REQ-007 SHALL have port wen, output, 1, buffer write strobe; high exactly when a write handshake completes.
REQ-008 SHALL have port write_ptr, output, $clog2(COLUMNS), column address for the current write.
REQ-009 SHALL have port rd_valid, output, 1, PAR_READ columns are available starting at read_ptr.
REQ-010 SHALL have port rd_ready, input, 1, consumer takes the PAR_READ-column group.
REQ-011 SHALL have port read_ptr, output, $clog2(COLUMNS), first column of the current read group.
REQ-012 SHALL have port flush, input, 1, discard all buffer contents.
REQ-013 SHALL have port count, output, $clog2(COLUMNS)+1, occupied columns.
REQ-014 SHALL have ports full and empty, output, 1 each; full = (count==COLUMNS), empty = (count==0).

Function
REQ-015 SHALL require COLUMNS % PAR_READ == 0 and 1 <= PAR_READ <= COLUMNS; otherwise elaboration error.
REQ-016 SHALL implement FSM states EMPTY (count==0), FILL (0<count<PAR_READ), AVAIL (count>=PAR_READ), FLUSH.
REQ-017 SHALL decode wr_ready = !flush && state!=FLUSH && count<COLUMNS, from registered count only (no same-cycle credit from a read).
REQ-018 SHALL decode rd_valid = !flush && state==AVAIL.
REQ-019 SHALL drive wen = wr_valid && wr_ready; on wen, write_ptr advances by 1 next cycle, COLUMNS-1 wraps to 0.
REQ-020 SHALL on read handshake (rd_valid && rd_ready) advance read_ptr by PAR_READ; if sum >= COLUMNS, subtract COLUMNS; sum computed one bit wider than the pointer.
REQ-021 SHALL update count next cycle as count + wen - (PAR_READ if read handshake); simultaneous write and read both apply in the same cycle.
REQ-022 SHALL move to the FSM state implied by the new count after each update, except as in REQ-023/024.
REQ-023 SHALL on flush high take priority over both handshakes and enter FLUSH next cycle with write_ptr=0, read_ptr=0, count=0.
REQ-024 SHALL hold FLUSH for exactly one cycle with wr_ready=0, rd_valid=0, then enter EMPTY; flush asserted again in FLUSH extends it.
REQ-025 SHALL never let count exceed COLUMNS or go below 0; the handshake rules enforce this without saturation logic.
REQ-026 SHALL give zero-cycle handshake latency: wen same cycle as wr_valid&&wr_ready; pointers and count update next edge.

Reset
REQ-027 SHALL on rst set state=EMPTY, write_ptr=0, read_ptr=0, count=0.
REQ-028 SHALL hold outputs during reset at wr_ready=1, rd_valid=0, wen=0, empty=1, full=0, with rst dominating flush and handshakes.
REQ-029 SHALL on rst asserted mid-operation discard all occupancy; no handshake completes on that edge.

Structure
REQ-030 SHALL place FSM state encodings (2-bit) and the pointer/count width constants in a shared package used by controller and bench.
REQ-031 SHALL implement each wrapping pointer as one sub-module, wrap_ptr (params DEPTH, STEP; inputs clk, rst, clr, inc), instantiated for write (STEP=1) and read (STEP=PAR_READ).
REQ-032 SHALL keep the FSM, count register and handshake decode in circ_buf_ctrl; no memory array inside.

Verification (COLUMNS=32, PAR_READ=4)
REQ-033 SHALL cover: reset, 3 writes -> count=3, state FILL, rd_valid=0; 4th write -> count=4, rd_valid=1, read_ptr=0.
REQ-034 SHALL cover: 32 writes, no reads -> full=1, wr_ready=0, write_ptr=0; 33rd wr_valid -> wen=0, count stays 32.
REQ-035 SHALL cover: read_ptr=28, count>=4, read handshake -> read_ptr=0 next cycle (wrap), count-=4.
REQ-036 SHALL cover: full and simultaneous wr_valid/rd_ready -> read occurs, no write (wr_ready=0), count=28; next cycle wr_ready=1.
REQ-037 SHALL cover: count=10 with wr_valid=1, rd_ready=1, flush=1 -> no wen, one FLUSH cycle, then EMPTY with pointers 0 and count 0.
REQ-038 SHALL cover: count=8, rst pulse concurrent with read handshake -> count=0, read_ptr=0, empty=1 next cycle.
